// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline stage with valid/ready handshake and forwarding tap.
// Define EX_MEM_SKID_EN for the two-entry skid buffer with registered in_ready; default is a single register.
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_out,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] store_data,
  input  logic [5:0]  ctrl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu,
  output logic        out_z,
  output logic        out_n,
  output logic [4:0]  out_rd,
  output logic [31:0] out_store_data,
  output logic [5:0]  out_ctrl,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [1:0]  occupancy
);

  localparam int CTRL_MEM_READ  = 5;
  localparam int CTRL_REG_WRITE = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic        z;
    logic        n;
    logic [4:0]  rd;
    logic [31:0] sdata;
    logic [5:0]  ctrl;
  } entry_t;

  entry_t in_entry;
  entry_t head;
  logic   in_fire;
  logic   out_fire;

  // Writes to r0 are architecturally void, so reg_write is cleared at capture time.
  always_comb begin
    in_entry       = '0;
    in_entry.alu   = alu_out;
    in_entry.z     = alu_z;
    in_entry.n     = alu_n;
    in_entry.rd    = rd_addr;
    in_entry.sdata = store_data;
    in_entry.ctrl  = ctrl;
    if (rd_addr == 5'd0) begin
      in_entry.ctrl[CTRL_REG_WRITE] = 1'b0;
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

`ifdef EX_MEM_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t skid;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            head  <= in_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head <= in_entry;
          end else if (in_fire) begin
            skid  <= in_entry;
            state <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path can fire.
          if (out_fire) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`else

  typedef enum logic {
    EMPTY = 1'b0,
    ONE   = 1'b1
  } state_t;

  state_t state;

  assign in_ready  = (state == EMPTY) || out_ready;
  assign out_valid = (state == ONE);
  assign occupancy = {1'b0, state == ONE};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      head  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            head  <= in_entry;
            state <= ONE;
          end
        end
        ONE: begin
          // An in-fire while full implies the head is draining in the same cycle.
          if (in_fire) begin
            head <= in_entry;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`endif

  assign out_alu        = head.alu;
  assign out_z          = head.z;
  assign out_n          = head.n;
  assign out_rd         = head.rd;
  assign out_store_data = head.sdata;
  assign out_ctrl       = head.ctrl;

  // Loads produce their value only in the memory stage, so they cannot be bypassed from here.
  assign fwd_valid = out_valid && head.ctrl[CTRL_REG_WRITE] && !head.ctrl[CTRL_MEM_READ];
  assign fwd_rd    = head.rd;
  assign fwd_data  = head.alu;

endmodule
